// File: rtl/ibex_axil_bridge_if.sv
// rtl/ibex_axil_bridge_if.sv - Ibex LSU data port and AXI4-Lite master bus bundle for the bridge
interface ibex_axil_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  data_req_i;
  logic                  data_gnt_o;
  logic                  data_rvalid_o;
  logic                  data_we_i;
  logic [DATA_W/8-1:0]   data_be_i;
  logic [ADDR_W-1:0]     data_addr_i;
  logic [DATA_W-1:0]     data_wdata_i;
  logic [DATA_W-1:0]     data_rdata_o;
  logic                  data_err_o;

  logic [ADDR_W-1:0]     m_awaddr;
  logic [2:0]            m_awprot;
  logic                  m_awvalid;
  logic                  m_awready;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_wstrb;
  logic                  m_wvalid;
  logic                  m_wready;
  logic [1:0]            m_bresp;
  logic                  m_bvalid;
  logic                  m_bready;
  logic [ADDR_W-1:0]     m_araddr;
  logic [2:0]            m_arprot;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [DATA_W-1:0]     m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rvalid;
  logic                  m_rready;

  // Bridge view: serves the core, masters the AXI-Lite crossbar.
  modport master (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output m_awaddr, m_awprot, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready,
    output m_araddr, m_arprot, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready
  );

  modport slave (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  m_awaddr, m_awprot, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready,
    input  m_araddr, m_arprot, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready
  );
endinterface

// File: rtl/ibex_axil_bridge.sv
// rtl/ibex_axil_bridge.sv - Ibex req/gnt/rvalid to single-outstanding AXI4-Lite master bridge
module ibex_axil_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic             clk_50M,
  input  logic             sys_rstn,
  ibex_axil_bridge_if.master bus
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR,
    WR_B,
    RESP
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   be_q;
  logic                we_q;
  logic                aw_done;
  logic                w_done;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                arvalid_q;
  logic                bready_q;
  logic                rready_q;
  logic                rvalid_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic grant;
  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;
  logic resp_fire;
  logic unused_resp_lsb;

  // Grant is the only combinational output; it must vanish while reset is held.
  assign grant     = sys_rstn && (state == IDLE) && bus.data_req_i;
  assign aw_hs     = awvalid_q && bus.m_awready;
  assign w_hs      = wvalid_q && bus.m_wready;
  assign aw_fin    = aw_done || aw_hs;
  assign w_fin     = w_done || w_hs;
  assign resp_fire = (rready_q && bus.m_rvalid) || (bready_q && bus.m_bvalid);

  assign unused_resp_lsb = bus.m_bresp[0] ^ bus.m_rresp[0];

  always_ff @(posedge clk_50M or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            addr_q  <= bus.data_addr_i;
            wdata_q <= bus.data_wdata_i;
            be_q    <= bus.data_be_i;
            we_q    <= bus.data_we_i;
            if (bus.data_we_i) begin
              state     <= WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end else begin
              state     <= RD_A;
              arvalid_q <= 1'b1;
            end
          end
        end
        RD_A: begin
          if (bus.m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_D;
          end
        end
        RD_D: begin
          if (bus.m_rvalid) begin
            rready_q <= 1'b0;
            rvalid_q <= 1'b1;
            state    <= RESP;
          end
        end
        WR: begin
          // AW and W complete independently; either may stall behind the other.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            bready_q <= 1'b1;
            state    <= WR_B;
          end
        end
        WR_B: begin
          if (bus.m_bvalid) begin
            bready_q <= 1'b0;
            rvalid_q <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          rvalid_q <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Bit 1 of the response separates SLVERR/DECERR from OKAY/EXOKAY.
      if (resp_fire) begin
        rdata_q <= we_q ? '0 : bus.m_rdata;
        err_q   <= we_q ? bus.m_bresp[1] : bus.m_rresp[1];
      end
    end
  end

  assign bus.data_gnt_o    = grant;
  assign bus.data_rvalid_o = rvalid_q;
  assign bus.data_rdata_o  = rdata_q;
  assign bus.data_err_o    = err_q;

  assign bus.m_awaddr  = addr_q;
  assign bus.m_awprot  = 3'b000;
  assign bus.m_awvalid = awvalid_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wstrb   = be_q;
  assign bus.m_wvalid  = wvalid_q;
  assign bus.m_bready  = bready_q;
  assign bus.m_araddr  = addr_q;
  assign bus.m_arprot  = 3'b000;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_rready  = rready_q;
endmodule
